// File: rtl/uart_program_receiver_pkg.sv
// Shared definitions for the UART program receiver: sync marker, error codes
// and the state encodings of the frame FSM and the UART byte receiver.
package uart_program_receiver_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_FRAMING  = 2'd1,
    ERR_LENGTH   = 2'd2,
    ERR_CHECKSUM = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    GET_LEN,
    GET_DATA,
    GET_CHK
  } frame_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_program_receiver_if.sv
// Loader write port plus host-facing status, driven by the program receiver.
interface uart_program_receiver_if #(
  parameter int ADDR_WIDTH = 5
);

  logic [7:0]            load_data;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic                  load_we;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [1:0]            err_code;

  modport master (
    output load_data, load_addr, load_we, busy, done, error, err_code
  );

  modport slave (
    input load_data, load_addr, load_we, busy, done, error, err_code
  );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, bit timer and receive FSM.
// Emits a one-cycle byte_valid on a good stop bit, or frame_err on a bad one.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  import uart_program_receiver_pkg::*;

  localparam int               CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_meta_q, rx_sync_q;
  logic             rx_prev_q, rx_prev_d;
  logic [1:0]       fill_q;
  logic             fall;

  // The synchroniser is preset high, so its output is not trusted until fill_q
  // shows two real samples; this stops a low line at reset release from
  // looking like a start bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b0;
      fill_q       <= 2'b00;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_prev_d;
      fill_q       <= {fill_q[0], 1'b1};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign rx_prev_d = fill_q[1] & rx_sync_q;
  assign fall      = rx_prev_q & ~rx_sync_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == MID) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            state_d      = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rx_sync_q) state_d = RX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_program_receiver.sv
// Program-image receiver: decodes sync/length/payload/checksum frames from the
// UART and issues one-cycle byte writes to the loader.
module uart_program_receiver
  import uart_program_receiver_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         ADDR_WIDTH   = 5,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input logic                      clock,
  input logic                      reset,
  input logic                      rx,
  uart_program_receiver_if.master  bus
);

  localparam int LEN_W   = ADDR_WIDTH + 1;
  localparam int MAX_LEN = 2 ** ADDR_WIDTH;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_frame_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (rx_valid),
    .byte_data  (rx_byte),
    .frame_err  (rx_frame_err)
  );

  frame_state_e          state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            chk_q, chk_d;
  logic [7:0]            load_data_q, load_data_d;
  logic [ADDR_WIDTH-1:0] load_addr_q, load_addr_d;
  logic                  load_we_q, load_we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  err_code_e             err_code_q, err_code_d;
  logic                  len_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_SYNC;
      len_q       <= '0;
      cnt_q       <= '0;
      chk_q       <= '0;
      load_data_q <= '0;
      load_addr_q <= '0;
      load_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      load_data_q <= load_data_d;
      load_addr_q <= load_addr_d;
      load_we_q   <= load_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

  assign len_ok = (rx_byte != 8'd0) && (int'(rx_byte) <= MAX_LEN);

  // A framing error outranks byte handling; it can only occur without a valid byte anyway.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    load_data_d = load_data_q;
    load_addr_d = load_addr_q;
    load_we_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    if (rx_frame_err && state_q != WAIT_SYNC) begin
      done_d     = 1'b0;
      error_d    = 1'b1;
      err_code_d = ERR_FRAMING;
      busy_d     = 1'b0;
      state_d    = WAIT_SYNC;
    end else if (rx_valid) begin
      case (state_q)
        WAIT_SYNC: begin
          if (rx_byte == SYNC_BYTE) begin
            done_d     = 1'b0;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
            busy_d     = 1'b1;
            state_d    = GET_LEN;
          end
        end
        GET_LEN: begin
          if (len_ok) begin
            len_d   = LEN_W'(rx_byte);
            chk_d   = rx_byte;
            cnt_d   = '0;
            state_d = GET_DATA;
          end else begin
            error_d    = 1'b1;
            err_code_d = ERR_LENGTH;
            busy_d     = 1'b0;
            state_d    = WAIT_SYNC;
          end
        end
        GET_DATA: begin
          load_data_d = rx_byte;
          load_addr_d = cnt_q[ADDR_WIDTH-1:0];
          load_we_d   = 1'b1;
          chk_d       = chk_q ^ rx_byte;
          cnt_d       = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = GET_CHK;
        end
        GET_CHK: begin
          if (rx_byte == chk_q) begin
            done_d = 1'b1;
          end else begin
            error_d    = 1'b1;
            err_code_d = ERR_CHECKSUM;
          end
          busy_d  = 1'b0;
          state_d = WAIT_SYNC;
        end
        default: state_d = WAIT_SYNC;
      endcase
    end
  end

  assign bus.load_data = load_data_q;
  assign bus.load_addr = load_addr_q;
  assign bus.load_we   = load_we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: doc/uart_program_receiver.md
Name: uart_program_receiver

Overview:
Upstream feeder for the program loader. Receives a program image over a UART line and issues one-cycle byte writes (data, address, write strobe) to the loader's write port. The UART byte receiver is built in; a small framing protocol (sync, length, payload, checksum) sits on top. Completion and error status go to the host-side status logic.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; must be >= 4 and even.
ADDR_WIDTH, 5, loader address width; maximum payload is 2**ADDR_WIDTH bytes.
SYNC_BYTE, 8'hA5, frame start marker.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high.
rx  in  1  UART serial input; idles high; 8N1, LSB first; asynchronous to clock.
load_data  out  8  byte for the loader's data_in.
load_addr  out  ADDR_WIDTH  address for the loader's addr.
load_we  out  1  one-cycle write strobe to the loader's write_enable.
busy  out  1  frame in progress.
done  out  1  last frame completed with a good checksum.
error  out  1  last frame aborted or failed.
err_code  out  2  cause: 0 none, 1 framing (bad stop bit), 2 bad length, 3 checksum mismatch.

Behaviour:
- Reset: all outputs 0. Frame FSM goes to WAIT_SYNC and the UART to RX_IDLE. Any byte in flight is dropped.
- rx passes through a 2-flop synchroniser preset to 1; all decoding uses the synchronised signal.
- UART states: RX_IDLE -> RX_START on a synchronised 1->0 edge.
  - RX_START: sample at CLKS_PER_BIT/2. If low, go to RX_DATA; if high, treat as a glitch and return to RX_IDLE.
  - RX_DATA: 8 samples, one every CLKS_PER_BIT cycles, LSB first.
  - RX_STOP: sample one bit period later. If high, emit byte_valid for 1 cycle with the byte. If low, emit frame_err for 1 cycle, then wait for rx high before returning to RX_IDLE.
- Frame FSM, advancing only on byte_valid or frame_err:
  - WAIT_SYNC: a byte equal to SYNC_BYTE clears done, error and err_code, sets busy, and goes to GET_LEN. Other bytes are ignored.
  - GET_LEN: LEN in 1..2**ADDR_WIDTH stores LEN, seeds chk = LEN, sets addr counter to 0, and goes to GET_DATA. Any other value raises error with err_code=2, clears busy, and returns to WAIT_SYNC.
  - GET_DATA: each byte drives load_data=byte, load_addr=counter and load_we=1, all on the cycle after byte_valid, for exactly 1 cycle. Then chk ^= byte and counter++. After the LEN-th byte, go to GET_CHK.
  - GET_CHK: byte == chk sets done. Otherwise set error with err_code=3. Either way clear busy and go to WAIT_SYNC.
- A frame_err in any state other than WAIT_SYNC raises error with err_code=1, clears busy, and returns to WAIT_SYNC. In WAIT_SYNC a frame_err is ignored.
- Bytes already written are not retracted on error. The host must resend the whole frame.
- load_data and load_addr hold their last values between strobes. Strobes are at least 10*CLKS_PER_BIT cycles apart, so the loader always returns to idle between writes.
- The address counter is ADDR_WIDTH+1 bits so it can count to LEN = 2**ADDR_WIDTH. load_addr uses its low ADDR_WIDTH bits and never wraps within a frame.
- done and error are levels and are mutually exclusive.
- Reset mid-frame: outputs cleared. A low rx at reset release does not start a byte; a high level must be seen first.

Decomposition:
- Shared package/include holds SYNC_BYTE, the err_code encodings, and the frame-FSM and UART state encodings.
- Sub-module uart_rx_byte contains the synchroniser, bit timer and UART FSM. Ports: clock, reset, rx, byte_valid, byte_data[7:0], frame_err.
- Top level holds the frame FSM, checksum, address counter and output registers.

Test Plan:
- CLKS_PER_BIT=4; send A5,03,11,22,33,chk=03^11^22^33=03 -> load_we pulses at addr 0,1,2 with data 11,22,33; done=1, error=0, busy=0.
- Send A5,03,11,22,33,FF -> three writes occur; then error=1, err_code=3, done=0.
- Send A5,00 and separately A5,21 -> no load_we pulses; error=1, err_code=2 for each.
- Send A5,20, then 32 bytes, then the correct XOR -> final write has addr=31; done=1.
- Send bytes 00,7E before A5 -> ignored. Then a byte with its stop bit forced low after A5,02 -> error=1, err_code=1. A following valid frame clears error and sets done.
- Glitch on rx low for 1 cycle -> no byte decoded. Reset asserted mid-payload -> all outputs 0 immediately; next full frame loads from addr 0.
